// File: rtl/clint_timer_if.sv
// MMIO strobe bus between the address mapper and the CLINT: word-offset address,
// write data and a one-cycle write strobe, with read data returned combinationally.
interface clint_timer_if;
    logic [15:0] a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;

    modport master (output a, output d, output we, input spo);
    modport slave  (input a, input d, input we, output spo);
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor: prescaled 64-bit mtime, mtimecmp and msip in the RISC-V CLINT layout.
// Optional feature macro: CLINT_MTIME_WR_EN makes mtime lo/hi writable.
module clint_timer #(
    parameter int unsigned DIV     = 50,
    parameter logic [63:0] CMP_RST = 64'hffff_ffff_ffff_ffff
) (
    input  logic          clk,
    input  logic          rst,
    clint_timer_if.slave  bus,
    output logic          irq_timer,
    output logic          irq_soft
);
    localparam int unsigned PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned WA_W  = 14;

    localparam logic [WA_W-1:0] WA_MSIP    = 14'h0000;
    localparam logic [WA_W-1:0] WA_CMP_LO  = 14'h1000;
    localparam logic [WA_W-1:0] WA_CMP_HI  = 14'h1001;
    localparam logic [WA_W-1:0] WA_TIME_LO = 14'h2ffe;
    localparam logic [WA_W-1:0] WA_TIME_HI = 14'h2fff;

    logic [PSC_W-1:0] psc;
    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic             msip;

    logic [WA_W-1:0]  wa_c;
    logic             tick_c;
    logic [PSC_W-1:0] psc_nxt_c;
    logic [63:0]      mtime_nxt_c;
    logic [63:0]      mtimecmp_nxt_c;
    logic             msip_nxt_c;
    logic             unused_addr_lsb;

    assign wa_c            = bus.a[15:2];
    assign unused_addr_lsb = ^bus.a[1:0];
    assign tick_c          = (psc == PSC_W'(DIV - 1));
    assign irq_soft        = msip;

    // Next-state for counters and writable registers.
    always_comb begin
        psc_nxt_c      = tick_c ? '0 : psc + PSC_W'(1);
        mtime_nxt_c    = tick_c ? mtime + 64'd1 : mtime;
        mtimecmp_nxt_c = mtimecmp;
        msip_nxt_c     = msip;
        if (bus.we) begin
            case (wa_c)
                WA_MSIP:   msip_nxt_c            = bus.d[0];
                WA_CMP_LO: mtimecmp_nxt_c[31:0]  = bus.d;
                WA_CMP_HI: mtimecmp_nxt_c[63:32] = bus.d;
`ifdef CLINT_MTIME_WR_EN
                // On a tick collision the untouched half keeps its pre-tick value.
                WA_TIME_LO: mtime_nxt_c = {mtime[63:32], bus.d};
                WA_TIME_HI: mtime_nxt_c = {bus.d, mtime[31:0]};
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc       <= '0;
            mtime     <= '0;
            mtimecmp  <= CMP_RST;
            msip      <= 1'b0;
            irq_timer <= 1'b0;
        end else begin
            psc       <= psc_nxt_c;
            mtime     <= mtime_nxt_c;
            mtimecmp  <= mtimecmp_nxt_c;
            msip      <= msip_nxt_c;
            irq_timer <= (mtime >= mtimecmp);
        end
    end

    // Side-effect-free combinational read port.
    always_comb begin
        bus.spo = '0;
        case (wa_c)
            WA_MSIP:    bus.spo = {31'd0, msip};
            WA_CMP_LO:  bus.spo = mtimecmp[31:0];
            WA_CMP_HI:  bus.spo = mtimecmp[63:32];
            WA_TIME_LO: bus.spo = mtime[31:0];
            WA_TIME_HI: bus.spo = mtime[63:32];
            default:    bus.spo = '0;
        endcase
    end
endmodule
